// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul_engine slice.
// Optional build macro used elsewhere: MATMUL_PERF_CNT_EN.
package matmul_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      DRAIN,
      WRITE,
      DONE
   } state_t;

   localparam logic SAT_TRUNC = 1'b0;
   localparam logic SAT_CLAMP = 1'b1;

   // Row-major linear index of element (row, col) in an n x n matrix.
   function automatic int unsigned lin_idx(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned n);
      return row * n + col;
   endfunction

endpackage

// File: rtl/matmul_engine_if.sv
// Command/status handshake and A/B/C memory bus of matmul_engine.
// master = command decoder + block RAMs side, slave = the engine.
interface matmul_engine_if #(
   parameter int N  = 16,
   parameter int DW = 8,
   parameter int AW = $clog2(N*N)
);
   logic          start;
   logic          abort;
   logic          signed_mode;
   logic          sat_mode;
   logic          busy;
   logic          done;
   logic          ovf;
   logic [AW-1:0] a_raddr;
   logic [DW-1:0] a_rdata;
   logic [AW-1:0] b_raddr;
   logic [DW-1:0] b_rdata;
   logic          res_we;
   logic [AW-1:0] res_waddr;
   logic [DW-1:0] res_wdata;

   modport master (
      output start, abort, signed_mode, sat_mode, a_rdata, b_rdata,
      input  busy, done, ovf, a_raddr, b_raddr, res_we, res_waddr, res_wdata
   );

   modport slave (
      input  start, abort, signed_mode, sat_mode, a_rdata, b_rdata,
      output busy, done, ovf, a_raddr, b_raddr, res_we, res_waddr, res_wdata
   );
endinterface

// File: rtl/matmul_mac_unit.sv
// Multiply-accumulate datapath: operand extension, one product per cycle,
// load-on-first accumulation and result saturation / overflow detection.
module matmul_mac_unit
   import matmul_pkg::*;
#(
   parameter int DW   = 8,
   parameter int ACCW = 2*DW+1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_valid,
   input  logic          i_first,
   input  logic          i_signed,
   input  logic          i_sat,
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   output logic [DW-1:0] o_res,
   output logic          o_ovf
);

   logic signed [2*DW-1:0] w_prod_s;
   logic        [2*DW-1:0] w_prod_u;
   logic        [ACCW-1:0] w_prod;
   logic        [ACCW-1:0] w_acc_nxt;
   logic        [ACCW-1:0] r_acc;

   // Product, next accumulator value and the DW-range result derived from it.
   // The result is taken from the next value so the final product, which
   // lands on the same edge the write is registered, is already included.
   always_comb begin
      w_prod_s = $signed({{DW{i_a[DW-1]}}, i_a}) * $signed({{DW{i_b[DW-1]}}, i_b});
      w_prod_u = {{DW{1'b0}}, i_a} * {{DW{1'b0}}, i_b};
      if (i_signed)
         w_prod = {{(ACCW-2*DW){w_prod_s[2*DW-1]}}, w_prod_s};
      else
         w_prod = {{(ACCW-2*DW){1'b0}}, w_prod_u};

      if (!i_valid)
         w_acc_nxt = r_acc;
      else if (i_first)
         w_acc_nxt = w_prod;
      else
         w_acc_nxt = r_acc + w_prod;

      if (i_signed)
         o_ovf = !((&w_acc_nxt[ACCW-1:DW-1]) || (~|w_acc_nxt[ACCW-1:DW-1]));
      else
         o_ovf = |w_acc_nxt[ACCW-1:DW];

      if (!o_ovf || i_sat == SAT_TRUNC)
         o_res = w_acc_nxt[DW-1:0];
      else if (i_signed)
         o_res = w_acc_nxt[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else
         o_res = '1;
   end

   // Accumulator register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_acc <= '0;
      else
         r_acc <= w_acc_nxt;
   end

endmodule

// File: rtl/matmul_engine.sv
// NxN matrix multiply C = A x B over synchronous-read block RAMs.
// Build option: define MATMUL_PERF_CNT_EN to add the 32-bit cycles port.
module matmul_engine
   import matmul_pkg::*;
#(
   parameter int N    = 16,
   parameter int DW   = 8,
   parameter int AW   = $clog2(N*N),
   parameter int ACCW = 2*DW+$clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   matmul_engine_if.slave bus
`ifdef MATMUL_PERF_CNT_EN
   ,
   output logic [31:0]  cycles
`endif
);

   localparam int          IW   = $clog2(N);
   localparam int unsigned NU   = N;
   localparam logic [IW-1:0] LAST = IW'(N-1);

   state_t        r_state;
   logic [IW-1:0] r_i, r_j, r_k, r_k_d;
   logic          r_v;
   logic          r_signed, r_sat;
   logic          r_busy, r_done, r_ovf, r_we;
   logic [AW-1:0] r_a_raddr, r_b_raddr, r_waddr;
   logic [DW-1:0] r_wdata;

   logic [IW-1:0] w_i_nxt, w_j_nxt;
   logic          w_last_elem;
   logic [DW-1:0] w_mac_res;
   logic          w_mac_ovf;

   function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] row,
                                             input logic [IW-1:0] col);
      return AW'(lin_idx(32'(row), 32'(col), NU));
   endfunction

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.ovf       = r_ovf;
   assign bus.a_raddr   = r_a_raddr;
   assign bus.b_raddr   = r_b_raddr;
   assign bus.res_we    = r_we;
   assign bus.res_waddr = r_waddr;
   assign bus.res_wdata = r_wdata;

   matmul_mac_unit #(.DW(DW), .ACCW(ACCW)) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_valid  (r_v),
      .i_first  (r_k_d == '0),
      .i_signed (r_signed),
      .i_sat    (r_sat),
      .i_a      (bus.a_rdata),
      .i_b      (bus.b_rdata),
      .o_res    (w_mac_res),
      .o_ovf    (w_mac_ovf)
   );

   // Next output element in row-major order.
   always_comb begin
      w_last_elem = (r_i == LAST) && (r_j == LAST);
      if (r_j == LAST) begin
         w_j_nxt = '0;
         w_i_nxt = r_i + IW'(1);
      end else begin
         w_j_nxt = r_j + IW'(1);
         w_i_nxt = r_i;
      end
   end

   // Control FSM. Read addresses are registered one edge ahead so the address
   // for index k is on the bus during the ISSUE cycle of k; the matching data
   // then arrives while r_v/r_k_d describe it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_i       <= '0;
         r_j       <= '0;
         r_k       <= '0;
         r_k_d     <= '0;
         r_v       <= 1'b0;
         r_signed  <= 1'b0;
         r_sat     <= SAT_TRUNC;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
         r_we      <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_a_raddr <= '0;
         r_b_raddr <= '0;
      end else begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_v     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_state   <= ISSUE;
                  r_busy    <= 1'b1;
                  r_signed  <= bus.signed_mode;
                  r_sat     <= bus.sat_mode;
                  r_ovf     <= 1'b0;
                  r_i       <= '0;
                  r_j       <= '0;
                  r_k       <= '0;
                  r_a_raddr <= '0;
                  r_b_raddr <= '0;
               end
            end
            default: begin
               if (bus.abort) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end else begin
                  case (r_state)
                     ISSUE: begin
                        r_v   <= 1'b1;
                        r_k_d <= r_k;
                        if (r_k == LAST) begin
                           r_state <= DRAIN;
                        end else begin
                           r_k       <= r_k + IW'(1);
                           r_a_raddr <= addr_of(r_i, r_k + IW'(1));
                           r_b_raddr <= addr_of(r_k + IW'(1), r_j);
                        end
                     end
                     DRAIN: begin
                        r_state <= WRITE;
                        r_we    <= 1'b1;
                        r_waddr <= addr_of(r_i, r_j);
                        r_wdata <= w_mac_res;
                        r_ovf   <= r_ovf | w_mac_ovf;
                     end
                     WRITE: begin
                        r_i <= w_i_nxt;
                        r_j <= w_j_nxt;
                        if (w_last_elem) begin
                           r_state <= DONE;
                           r_busy  <= 1'b0;
                           r_done  <= 1'b1;
                        end else begin
                           r_state   <= ISSUE;
                           r_k       <= '0;
                           r_a_raddr <= addr_of(w_i_nxt, '0);
                           r_b_raddr <= addr_of('0, w_j_nxt);
                        end
                     end
                     DONE: begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                     end
                     default: r_state <= IDLE;
                  endcase
               end
            end
         endcase
      end
   end

`ifdef MATMUL_PERF_CNT_EN
   logic [31:0] r_cycles;

   assign cycles = r_cycles;

   // Busy-cycle counter: cleared on start acceptance, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cycles <= '0;
      else if (r_state == IDLE && bus.start)
         r_cycles <= '0;
      else if (r_busy && r_cycles != '1)
         r_cycles <= r_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_matmul_engine.sv
// Self-checking bench for matmul_engine (N=4, DW=8) with a write scoreboard.
// Define MATMUL_PERF_CNT_EN to also check the cycles port.
module tb_matmul_engine;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int AW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   matmul_engine_if #(.N(N), .DW(DW), .AW(AW)) bus ();

`ifdef MATMUL_PERF_CNT_EN
   logic [31:0] cycles;
`endif

   matmul_engine #(.N(N), .DW(DW), .AW(AW), .ACCW(2*DW+2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef MATMUL_PERF_CNT_EN
      ,
      .cycles(cycles)
`endif
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem_a [N*N];
   logic [DW-1:0] mem_b [N*N];

   // Synchronous-read A/B memories.
   always @(posedge clk) begin
      bus.a_rdata <= mem_a[bus.a_raddr];
      bus.b_rdata <= mem_b[bus.b_raddr];
   end

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t sb[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  n_writes = 0;

   // Scoreboard monitor: every write must match the next expected entry.
   always @(negedge clk) begin
      if (rst_n) begin
         n_checks++;
         if (bus.res_we) begin
            n_writes++;
            if (sb.size() == 0) begin
               n_errors++;
               $display("FAIL wr_unexpected: got addr=%0d data=%0d, required no write",
                        bus.res_waddr, bus.res_wdata);
            end else begin
               wr_t e;
               e = sb.pop_front();
               if ({bus.res_waddr, bus.res_wdata} !== e) begin
                  n_errors++;
                  $display("FAIL wr_data: got addr=%0d data=%0d, required addr=%0d data=%0d",
                           bus.res_waddr, bus.res_wdata, e.addr, e.data);
               end
            end
         end else if (bus.res_waddr !== '0 || bus.res_wdata !== '0) begin
            n_errors++;
            $display("FAIL wr_idle_zero: got addr=%0d data=%0d, required 0/0",
                     bus.res_waddr, bus.res_wdata);
         end
      end
   end

   // Reference model: pushes expected writes in row-major order.
   task automatic push_expected(input logic sgn, input logic sat, output logic exp_ovf);
      int lo, hi;
      lo = sgn ? -128 : 0;
      hi = sgn ? 127 : 255;
      exp_ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            int acc;
            logic [DW-1:0] d;
            acc = 0;
            for (int k = 0; k < N; k++) begin
               int av, bv;
               av = sgn ? int'($signed(mem_a[i*N+k])) : int'(mem_a[i*N+k]);
               bv = sgn ? int'($signed(mem_b[k*N+j])) : int'(mem_b[k*N+j]);
               acc += av * bv;
            end
            if (acc < lo || acc > hi) exp_ovf = 1'b1;
            if (sat && acc > hi)      d = 8'(hi);
            else if (sat && acc < lo) d = 8'(lo);
            else                      d = 8'(acc);
            sb.push_back({AW'(i*N+j), d});
         end
      end
   endtask

   // Starts a run and observes it until 5 cycles past done (bounded).
   // Cycle 1 is the cycle that begins at the start-acceptance edge.
   task automatic run(input logic sgn, input logic sat, input int restart_at,
                      input logic with_abort, output int done_cyc,
                      output int busy_cyc, output int done_cnt);
      int cyc;
      @(negedge clk);
      bus.signed_mode = sgn;
      bus.sat_mode    = sat;
      bus.start       = 1'b1;
      bus.abort       = with_abort;
      @(negedge clk);
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.signed_mode = ~sgn;
      bus.sat_mode    = ~sat;
      cyc = 1; done_cyc = -1; busy_cyc = 0; done_cnt = 0;
      while (cyc <= 200) begin
         if (bus.busy) busy_cyc++;
         if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         bus.start = (cyc == restart_at);
         if (done_cyc > 0 && cyc >= done_cyc + 5) break;
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
   endtask

   task automatic fill_identity();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            mem_a[r*N+c] = (r == c) ? 8'd1 : 8'd0;
            mem_b[r*N+c] = 8'(r*N+c);
         end
   endtask

   task automatic fill_const(input logic [DW-1:0] v);
      for (int x = 0; x < N*N; x++) begin
         mem_a[x] = v;
         mem_b[x] = v;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.done, bus.ovf, bus.res_we} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_flags: got busy/done/ovf/we=%b, required 0000",
                  {bus.busy, bus.done, bus.ovf, bus.res_we});
      end
      n_checks++;
      if ({bus.a_raddr, bus.b_raddr} !== '0) begin
         n_errors++;
         $display("FAIL reset_raddr: got a=%0d b=%0d, required 0/0", bus.a_raddr, bus.b_raddr);
      end
      n_checks++;
      if ({bus.res_waddr, bus.res_wdata} !== '0) begin
         n_errors++;
         $display("FAIL reset_wbus: got addr=%0d data=%0d, required 0/0",
                  bus.res_waddr, bus.res_wdata);
      end
`ifdef MATMUL_PERF_CNT_EN
      n_checks++;
      if (cycles !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_cycles: got %0d, required 0", cycles);
      end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_identity();
      logic eo;
      int dc, bc, dn, w0;
      fill_identity();
      push_expected(1'b0, 1'b0, eo);
      w0 = n_writes;
      run(1'b0, 1'b0, 0, 1'b0, dc, bc, dn);
      n_checks++;
      if (dc !== 97) begin n_errors++; $display("FAIL ident_done_cycle: got %0d, required 97", dc); end
      n_checks++;
      if (bc !== 96) begin n_errors++; $display("FAIL ident_busy_cycles: got %0d, required 96", bc); end
      n_checks++;
      if (dn !== 1) begin n_errors++; $display("FAIL ident_done_pulses: got %0d, required 1", dn); end
      n_checks++;
      if (n_writes - w0 !== 16 || sb.size() !== 0) begin
         n_errors++;
         $display("FAIL ident_writes: got %0d writes, %0d pending, required 16/0", n_writes - w0, sb.size());
      end
      n_checks++;
      if (bus.ovf !== 1'b0) begin n_errors++; $display("FAIL ident_ovf: got %b, required 0", bus.ovf); end
`ifdef MATMUL_PERF_CNT_EN
      n_checks++;
      if (cycles !== 32'd96) begin n_errors++; $display("FAIL perf_cycles: got %0d, required 96", cycles); end
`endif
   endtask

   task automatic test_saturate();
      logic eo;
      int dc, bc, dn;
      fill_const(8'd255);
      for (int m = 0; m < 2; m++) begin
         logic sat;
         sat = (m == 0);
         push_expected(1'b0, sat, eo);
         run(1'b0, sat, 0, 1'b0, dc, bc, dn);
         n_checks++;
         if (dc !== 97 || sb.size() !== 0) begin
            n_errors++;
            $display("FAIL sat%0d_run: got done@%0d pending=%0d, required 97/0", sat, dc, sb.size());
         end
         n_checks++;
         if (bus.ovf !== eo) begin n_errors++; $display("FAIL sat%0d_ovf: got %b, required %b", sat, bus.ovf, eo); end
      end
   endtask

   task automatic test_signed();
      logic eo;
      int dc, bc, dn;
      fill_const(8'd0);
      mem_a[0] = 8'h80; mem_a[1] = 8'd1; mem_a[4] = 8'd2; mem_a[5] = 8'hFF;
      mem_b[0] = 8'hFF; mem_b[1] = 8'd0; mem_b[4] = 8'd3; mem_b[5] = 8'd5;
      for (int m = 0; m < 2; m++) begin
         logic sat;
         sat = (m == 0);
         push_expected(1'b1, sat, eo);
         run(1'b1, sat, 0, 1'b0, dc, bc, dn);
         n_checks++;
         if (dc !== 97 || sb.size() !== 0) begin
            n_errors++;
            $display("FAIL signed%0d_run: got done@%0d pending=%0d, required 97/0", sat, dc, sb.size());
         end
         n_checks++;
         if (bus.ovf !== 1'b1) begin n_errors++; $display("FAIL signed%0d_ovf: got %b, required 1", sat, bus.ovf); end
      end
   endtask

   task automatic test_random();
      logic eo;
      int dc, bc, dn;
      for (int m = 0; m < 3; m++) begin
         logic sgn, sat;
         sgn = m[0];
         sat = m[1];
         for (int x = 0; x < N*N; x++) begin
            mem_a[x] = 8'($urandom_range(0, 255));
            mem_b[x] = 8'($urandom_range(0, 255));
         end
         push_expected(sgn, sat, eo);
         run(sgn, sat, 0, 1'b0, dc, bc, dn);
         n_checks++;
         if (dc !== 97 || sb.size() !== 0 || bus.ovf !== eo) begin
            n_errors++;
            $display("FAIL random%0d: got done@%0d pending=%0d ovf=%b, required 97/0/%b",
                     m, dc, sb.size(), bus.ovf, eo);
         end
      end
   endtask

   task automatic test_abort();
      logic eo;
      int dc, bc, dn, w0, late_busy, late_done;
      fill_const(8'd255);
      push_expected(1'b0, 1'b1, eo);
      w0 = n_writes;
      @(negedge clk);
      bus.signed_mode = 1'b0; bus.sat_mode = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 1; c < 20; c++) @(negedge clk);
      bus.abort = 1'b1;
      @(posedge clk);
      #1 sb.delete();
      @(negedge clk);
      bus.abort = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b, required 0", bus.busy); end
      n_checks++;
      if (n_writes - w0 !== 3) begin n_errors++; $display("FAIL abort_writes: got %0d, required 3", n_writes - w0); end
      late_busy = 0; late_done = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus.busy) late_busy++;
         if (bus.done) late_done++;
         @(negedge clk);
      end
      n_checks++;
      if (late_busy !== 0 || late_done !== 0) begin
         n_errors++;
         $display("FAIL abort_quiet: got busy=%0d done=%0d cycles, required 0/0", late_busy, late_done);
      end
      n_checks++;
      if (bus.ovf !== 1'b1) begin n_errors++; $display("FAIL abort_ovf_kept: got %b, required 1", bus.ovf); end
`ifdef MATMUL_PERF_CNT_EN
      n_checks++;
      if (cycles !== 32'd20) begin n_errors++; $display("FAIL abort_cycles: got %0d, required 20", cycles); end
`endif
      fill_identity();
      push_expected(1'b0, 1'b0, eo);
      run(1'b0, 1'b0, 0, 1'b0, dc, bc, dn);
      n_checks++;
      if (dc !== 97 || sb.size() !== 0 || bus.ovf !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_restart: got done@%0d pending=%0d ovf=%b, required 97/0/0", dc, sb.size(), bus.ovf);
      end
   endtask

   task automatic test_back_to_back();
      logic eo;
      int dc, bc, dn;
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL idle_abort_busy: got %b, required 0", bus.busy); end
      fill_identity();
      push_expected(1'b0, 1'b0, eo);
      run(1'b0, 1'b0, 30, 1'b1, dc, bc, dn);
      n_checks++;
      if (dc !== 97 || dn !== 1 || sb.size() !== 0) begin
         n_errors++;
         $display("FAIL restart_ignored: got done@%0d pulses=%0d pending=%0d, required 97/1/0", dc, dn, sb.size());
      end
      n_checks++;
      if (bc !== 96) begin n_errors++; $display("FAIL restart_busy: got %0d, required 96", bc); end
   endtask

   task automatic test_reset_midrun();
      logic eo;
      int w0, late_busy, late_done;
      for (int x = 0; x < N*N; x++) begin
         mem_a[x] = 8'($urandom_range(0, 255));
         mem_b[x] = 8'($urandom_range(0, 255));
      end
      push_expected(1'b0, 1'b1, eo);
      @(negedge clk);
      bus.signed_mode = 1'b0; bus.sat_mode = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 1; c < 42; c++) @(negedge clk);
      n_checks++;
      if (bus.res_we !== 1'b1 || bus.busy !== 1'b1) begin
         n_errors++;
         $display("FAIL midrun_state: got we=%b busy=%b, required 1/1", bus.res_we, bus.busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.ovf, bus.res_we} !== 4'b0000 ||
          {bus.a_raddr, bus.b_raddr, bus.res_waddr, bus.res_wdata} !== '0) begin
         n_errors++;
         $display("FAIL async_reset: got busy=%b done=%b ovf=%b we=%b a=%0d b=%0d wa=%0d wd=%0d, required all 0",
                  bus.busy, bus.done, bus.ovf, bus.res_we, bus.a_raddr, bus.b_raddr,
                  bus.res_waddr, bus.res_wdata);
      end
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      w0 = n_writes; late_busy = 0; late_done = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.busy) late_busy++;
         if (bus.done) late_done++;
      end
      n_checks++;
      if (late_busy !== 0 || late_done !== 0 || n_writes - w0 !== 0) begin
         n_errors++;
         $display("FAIL reset_idle: got busy=%0d done=%0d writes=%0d, required 0/0/0",
                  late_busy, late_done, n_writes - w0);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.signed_mode = 1'b0;
      bus.sat_mode = 1'b0;
      test_reset();
      test_identity();
      test_saturate();
      test_signed();
      test_random();
      test_abort();
      test_back_to_back();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/matmul_engine.md
Name: matmul_engine

Overview:
- Parametrised NxN matrix-multiply engine computing C = A x B, with elements read from two synchronous-read memories and results written to a third.
- Successor to the fixed 16x16 8-bit engine in the UART/FPGA test path. Adds configurable dimension, data and accumulator width, and signed/unsigned operands.
- Adds truncate/saturate result policy, a pipelined MAC (one product per cycle), a busy/abort handshake and a sticky overflow flag.
- Sits between the UART command decoder (start/abort, mode) and the A/B/C block RAMs.

Parameters:
- N, 16, matrix dimension (2..16, any integer); element (r,c) address = r*N + c.
- DW, 8, element data width for A, B and C.
- AW, $clog2(N*N), memory address width.
- ACCW, 2*DW+$clog2(N), accumulator width; guarantees no accumulator overflow.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin run; sampled only in IDLE.
- abort  in  1  synchronous cancel; honoured in any non-IDLE state.
- signed_mode  in  1  1 = two's-complement operands; latched at start.
- sat_mode  in  1  1 = saturate result, 0 = keep low DW bits; latched at start.
- busy  out  1  high from the cycle after start acceptance until done or abort.
- a_raddr  out  AW  A read address; data arrives 1 cycle later.
- a_rdata  in  DW  A read data.
- b_raddr  out  AW  B read address; data arrives 1 cycle later.
- b_rdata  in  DW  B read data.
- res_we  out  1  result write strobe.
- res_waddr  out  AW  result address i*N+j.
- res_wdata  out  DW  result data.
- done  out  1  single-cycle completion pulse.
- ovf  out  1  sticky: some element fell outside the DW range; cleared at start.
- cycles  out  32  present only with MATMUL_PERF_CNT_EN.

Behaviour:
- Reset values: busy=0, res_we=0, res_waddr=0, res_wdata=0, a_raddr=0, b_raddr=0, done=0, ovf=0, cycles=0. State=IDLE; i, j, k, accumulator and pipeline valid bit all 0.
- Reset mid-run: immediate return to IDLE; no write, no done.
- IDLE:
  - start=1 latches signed_mode and sat_mode, clears ovf and i, j, k, then goes to ISSUE.
  - All other inputs are ignored.
- ISSUE (N cycles per element):
  - Drives a_raddr = i*N+k and b_raddr = k*N+j, increments k each cycle, and sets pipeline valid v=1 with k_d=k.
  - After issuing k=N-1, goes to DRAIN.
- MAC, on cycles with v=1:
  - prod = a_rdata*b_rdata, sign- or zero-extended to ACCW according to latched signed_mode.
  - acc <= (k_d==0) ? prod : acc+prod. No explicit clear state.
- DRAIN (1 cycle): final product is accumulated; v=0.
- WRITE (1 cycle):
  - res_we=1, res_waddr=i*N+j.
  - res_wdata = acc[DW-1:0] when sat_mode=0.
  - When sat_mode=1, res_wdata = acc clamped to [0, 2^DW-1] (unsigned) or [-2^(DW-1), 2^(DW-1)-1] (signed).
  - ovf is set if acc is out of that range, independent of sat_mode.
  - Then advance j; at j=N-1, wrap j to 0 and increment i. If i=j=N-1, go to DONE; otherwise go to ISSUE with k=0.
- DONE: done=1 for exactly 1 cycle, busy=0, then IDLE.
- Outside ISSUE, a_raddr and b_raddr hold their last value. res_waddr and res_wdata are 0 when res_we=0.
- Timing:
  - Each element takes N+2 cycles.
  - The done pulse occurs N*N*(N+2)+1 cycles after the start-acceptance edge.
  - busy is high for N*N*(N+2) cycles.
- abort: next state IDLE, busy=0 the following cycle. No res_we once abort is sampled; no done. ovf keeps its value.
- start while busy: ignored. abort in IDLE: ignored. start and abort both asserted in IDLE: start wins.

Optional Feature:
- Macro: MATMUL_PERF_CNT_EN.
- When defined, port cycles[31:0] exists.
  - Cleared at start acceptance; increments every cycle busy=1; frozen at done or abort.
  - Saturates at 2^32-1.
- When undefined, the port and counter are absent and all other behaviour is identical.

Decomposition:
- Package matmul_pkg holds the state enum (IDLE, ISSUE, DRAIN, WRITE, DONE) and the mode encodings SAT_TRUNC=0 and SAT_CLAMP=1.
- Sub-module matmul_mac_unit, parametrised on DW and ACCW:
  - Handles extension, multiply, accumulate with load-on-first, and the saturation/overflow output logic.
- The top level keeps the FSM, the index counters and the address generation.

Test Plan:
- Identity test: N=4, DW=8, unsigned, A=identity, B[r][c]=r*4+c -> C equals B; 16 writes at addresses 0..15 in order; done at cycle 97; ovf=0.
- Unsigned saturate vs truncate: N=4, all A=B=255, sat_mode=1 -> every C=255, ovf=1. Same data with sat_mode=0 -> every C=0x04 (260100 mod 256), ovf=1.
- Signed mode: N=2, A=[[-128,1],[2,-1]], B=[[-1,0],[3,5]], sat_mode=1 -> C=[[127,5],[-5,-5]] (raw 131 clamped), ovf=1.
- Abort: abort asserted at cycle 20 of an N=4 run -> no res_we after the abort edge, busy low the next cycle, no done pulse. A fresh start then completes normally with ovf cleared.
- Busy handshake: start pulsed again mid-run -> ignored, single done pulse. rst_n asserted mid-run -> all outputs return to 0 asynchronously.
- Performance counter: with MATMUL_PERF_CNT_EN and N=4 -> cycles=96 after done.
